// File: rtl/audio_fifo_sched.sv
// Write-side scheduler for the audio sample FIFO: picks the software or tone source,
// paces the tone source with a sample-rate divider and throttles on fill-level hysteresis.
module audio_fifo_sched #(
    parameter int DATA_W = 32,
    parameter int USED_W = 12,
    parameter int HI_WM  = 3072,
    parameter int LO_WM  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] src0_data,
    input  logic              src0_valid,
    output logic              src0_ready,
    input  logic [DATA_W-1:0] src1_data,
    input  logic              src1_valid,
    output logic              src1_ready,
    input  logic              sel,
    input  logic              pause,
    input  logic              stop,
    input  logic [31:0]       div_freq,
    input  logic              fifo_full,
    input  logic [USED_W-1:0] fifo_used,
    output logic              fifo_wrreq,
    output logic [DATA_W-1:0] fifo_data,
    output logic              fifo_flush,
    output logic [1:0]        state_o,
    output logic [31:0]       wr_count,
    output logic [31:0]       starve_count
);

    localparam logic [1:0] ST_STOPPED  = 2'd0;
    localparam logic [1:0] ST_FILL     = 2'd1;
    localparam logic [1:0] ST_THROTTLE = 2'd2;
    localparam logic [1:0] ST_PAUSED   = 2'd3;

    localparam logic [USED_W-1:0] HI_LVL = USED_W'(HI_WM);
    localparam logic [USED_W-1:0] LO_LVL = USED_W'(LO_WM);

    logic [1:0]  state, state_nxt;
    logic        sel_q;
    logic [31:0] div_cnt;
    logic        running, sel_gap, tick, accept, starve, flush_entry;

    assign running     = (state == ST_FILL) || (state == ST_THROTTLE);
    // The cycle in which sel differs from last cycle's sel is a dead cycle for both sources.
    assign sel_gap     = (sel != sel_q);
    assign tick        = running && (div_cnt == 32'd0) && !sel_gap;
    assign accept      = (state == ST_FILL) && !stop && !pause && !fifo_full && !sel_gap &&
                         (sel ? (src1_valid && tick) : src0_valid);
    assign starve      = (state == ST_FILL) && !stop && !pause && sel && tick && !src1_valid;
    assign flush_entry = stop && (state != ST_STOPPED);

    assign src0_ready  = accept && !sel;
    assign src1_ready  = accept && sel;
    assign state_o     = state;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_STOPPED;
        end else begin
            case (state)
                ST_STOPPED:  state_nxt = ST_FILL;
                ST_PAUSED:   if (!pause) state_nxt = ST_FILL;
                ST_FILL: begin
                    if (pause)                  state_nxt = ST_PAUSED;
                    else if (fifo_used >= HI_LVL) state_nxt = ST_THROTTLE;
                end
                ST_THROTTLE: begin
                    if (pause)                  state_nxt = ST_PAUSED;
                    else if (fifo_used <= LO_LVL) state_nxt = ST_FILL;
                end
                default:     state_nxt = ST_STOPPED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_STOPPED;
            sel_q      <= 1'b0;
            fifo_flush <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel_q      <= sel;
            fifo_flush <= flush_entry;
        end
    end

    // Divider reloads while idle or on a source switch; missed ticks are simply dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= 32'd0;
        end else if (!running || sel_gap || (div_cnt == 32'd0)) begin
            div_cnt <= div_freq;
        end else begin
            div_cnt <= div_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_wrreq <= 1'b0;
            fifo_data  <= '0;
        end else begin
            fifo_wrreq <= accept;
            if (accept) begin
                fifo_data <= sel ? src1_data : src0_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count     <= 32'd0;
            starve_count <= 32'd0;
        end else if (flush_entry) begin
            wr_count     <= 32'd0;
            starve_count <= 32'd0;
        end else begin
            if (accept && (wr_count != 32'hFFFF_FFFF)) begin
                wr_count <= wr_count + 32'd1;
            end
            if (starve && (starve_count != 32'hFFFF_FFFF)) begin
                starve_count <= starve_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_fifo_sched.sv
// Bench for audio_fifo_sched: directed vector table, hand sequences for pacing and
// starvation, and a randomized run compared against a cycle-level behavioural model.
module tb_audio_fifo_sched;

    localparam int HI = 3072;
    localparam int LO = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] src0_data, src1_data;
    logic        src0_valid, src1_valid, src0_ready, src1_ready;
    logic        sel, pause, stop, fifo_full;
    logic [31:0] div_freq;
    logic [11:0] fifo_used;
    logic        fifo_wrreq, fifo_flush;
    logic [31:0] fifo_data, wr_count, starve_count;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_fifo_sched dut (
        .clk(clk), .reset_n(reset_n),
        .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
        .sel(sel), .pause(pause), .stop(stop), .div_freq(div_freq),
        .fifo_full(fifo_full), .fifo_used(fifo_used),
        .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_flush(fifo_flush),
        .state_o(state_o), .wr_count(wr_count), .starve_count(starve_count)
    );

    // Behavioural model: state as an int, tick countdown as "cycles until next sample".
    int          m_state;
    int          m_wait;
    bit          m_prev_sel;
    bit          m_wrreq, m_flush, m_acc, m_tick;
    logic [31:0] m_data;
    longint      m_wr, m_starve;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_prev_sel = 0;
        m_wrreq = 0; m_flush = 0; m_data = 0; m_wr = 0; m_starve = 0;
    endtask

    task automatic model_comb();
        bit in_run;
        bit switching;
        in_run    = (m_state == 1) || (m_state == 2);
        switching = (sel != m_prev_sel);
        m_tick    = in_run && (m_wait == 0) && !switching;
        m_acc     = (m_state == 1) && !stop && !pause && !fifo_full && !switching &&
                    (sel ? (src1_valid && m_tick) : src0_valid);
    endtask

    task automatic model_update();
        int nst;
        if (stop)                                   nst = 0;
        else if (m_state == 0)                      nst = 1;
        else if (pause)                             nst = 3;
        else if (m_state == 3)                      nst = 1;
        else if (m_state == 1 && fifo_used >= HI)   nst = 2;
        else if (m_state == 2 && fifo_used <= LO)   nst = 1;
        else                                        nst = m_state;
        m_flush = stop && (m_state != 0);
        m_wrreq = m_acc;
        if (m_acc) m_data = sel ? src1_data : src0_data;
        if (m_flush) begin
            m_wr = 0; m_starve = 0;
        end else begin
            if (m_acc && m_wr < 64'hFFFF_FFFF) m_wr++;
            if (m_state == 1 && !stop && !pause && sel && m_tick && !src1_valid &&
                m_starve < 64'hFFFF_FFFF) m_starve++;
        end
        if (!((m_state == 1) || (m_state == 2)) || sel != m_prev_sel || m_wait == 0)
            m_wait = int'(div_freq);
        else
            m_wait--;
        m_prev_sel = sel;
        m_state    = nst;
    endtask

    // One clock: inputs already driven at the negedge; check ready, clock, check registers.
    task automatic step();
        #1;
        model_comb();
        check("src0_ready", {63'd0, src0_ready}, {63'd0, m_acc && !sel});
        check("src1_ready", {63'd0, src1_ready}, {63'd0, m_acc && sel});
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("state",   {62'd0, state_o}, 64'(m_state));
        check("wrreq",   {63'd0, fifo_wrreq}, {63'd0, m_wrreq});
        check("data",    {32'd0, fifo_data}, {32'd0, m_data});
        check("flush",   {63'd0, fifo_flush}, {63'd0, m_flush});
        check("wr_cnt",  {32'd0, wr_count}, m_wr);
        check("starve",  {32'd0, starve_count}, m_starve);
    endtask

    typedef struct {
        logic        stop, pause, full;
        logic [11:0] used;
        logic [31:0] data;
        logic        exp_rdy0;
        logic [1:0]  exp_state;
        logic        exp_wrreq;
        logic [31:0] exp_data;
        logic [31:0] exp_wr;
        logic        exp_flush;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int last_wr, gap_bad, n_wr, rdy0_seen, bound;

        // stop pause full used data | rdy0 state wrreq data wr flush
        vecs[0]  = '{1, 0, 0, 12'd0,    32'h11, 0, 2'd0, 0, 32'h00, 0, 0};
        vecs[1]  = '{0, 0, 0, 12'd0,    32'h11, 0, 2'd1, 0, 32'h00, 0, 0};
        vecs[2]  = '{0, 0, 0, 12'd0,    32'h22, 1, 2'd1, 1, 32'h22, 1, 0};
        vecs[3]  = '{0, 0, 0, 12'd0,    32'h33, 1, 2'd1, 1, 32'h33, 2, 0};
        vecs[4]  = '{0, 0, 1, 12'd0,    32'h44, 0, 2'd1, 0, 32'h33, 2, 0};
        vecs[5]  = '{0, 0, 0, 12'd0,    32'h55, 1, 2'd1, 1, 32'h55, 3, 0};
        vecs[6]  = '{0, 0, 0, 12'd3072, 32'h66, 1, 2'd2, 1, 32'h66, 4, 0};
        vecs[7]  = '{0, 0, 0, 12'd3072, 32'h77, 0, 2'd2, 0, 32'h66, 4, 0};
        vecs[8]  = '{0, 0, 0, 12'd1025, 32'h88, 0, 2'd2, 0, 32'h66, 4, 0};
        vecs[9]  = '{0, 0, 0, 12'd1024, 32'h99, 0, 2'd1, 0, 32'h66, 4, 0};
        vecs[10] = '{0, 0, 0, 12'd1024, 32'hAA, 1, 2'd1, 1, 32'hAA, 5, 0};
        vecs[11] = '{0, 1, 0, 12'd0,    32'hBB, 0, 2'd3, 0, 32'hAA, 5, 0};
        vecs[12] = '{1, 1, 0, 12'd0,    32'hCC, 0, 2'd0, 0, 32'hAA, 0, 1};
        vecs[13] = '{0, 0, 0, 12'd0,    32'hDD, 0, 2'd1, 0, 32'hAA, 0, 0};

        reset_n = 1'b0;
        src0_data = 0; src1_data = 0; src0_valid = 0; src1_valid = 0;
        sel = 0; pause = 0; stop = 1; div_freq = 0; fifo_full = 0; fifo_used = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", {62'd0, state_o}, 64'd0);
        check("rst_wrreq", {63'd0, fifo_wrreq}, 64'd0);
        check("rst_data",  {32'd0, fifo_data}, 64'd0);
        check("rst_flush", {63'd0, fifo_flush}, 64'd0);
        check("rst_cnts",  {wr_count, starve_count}, 64'd0);
        check("rst_ready", {62'd0, src0_ready, src1_ready}, 64'd0);
        reset_n = 1'b1;

        // Directed table: src0 stream, full gating, watermark hysteresis, pause vs stop.
        src0_valid = 1;
        for (int i = 0; i < 14; i++) begin
            stop = vecs[i].stop; pause = vecs[i].pause; fifo_full = vecs[i].full;
            fifo_used = vecs[i].used; src0_data = vecs[i].data;
            #1;
            check($sformatf("v%0d_rdy0", i), {63'd0, src0_ready}, {63'd0, vecs[i].exp_rdy0});
            step();
            check($sformatf("v%0d_state", i), {62'd0, state_o}, {62'd0, vecs[i].exp_state});
            check($sformatf("v%0d_wrreq", i), {63'd0, fifo_wrreq}, {63'd0, vecs[i].exp_wrreq});
            check($sformatf("v%0d_data", i), {32'd0, fifo_data}, {32'd0, vecs[i].exp_data});
            check($sformatf("v%0d_wr", i), {32'd0, wr_count}, {32'd0, vecs[i].exp_wr});
            check($sformatf("v%0d_flush", i), {63'd0, fifo_flush}, {63'd0, vecs[i].exp_flush});
        end

        // Tone pacing: div_freq=3 gives one write every 4 cycles after the switch gap.
        sel = 1; div_freq = 3; src1_valid = 1; src0_valid = 1;
        last_wr = -1; gap_bad = 0; n_wr = 0; rdy0_seen = 0;
        for (int c = 0; c < 40; c++) begin
            src1_data = 32'h1000 + c;
            #1;
            if (src0_ready) rdy0_seen++;
            step();
            if (fifo_wrreq) begin
                if (last_wr >= 0 && c - last_wr != 4) gap_bad++;
                last_wr = c;
                n_wr++;
            end
        end
        check("tone_writes", 64'(n_wr), 64'd9);
        check("tone_period", 64'(gap_bad), 64'd0);
        check("tone_rdy0", 64'(rdy0_seen), 64'd0);

        // Starvation: div_freq=9, no tone samples for 100 FILL cycles.
        stop = 1; div_freq = 9; src1_valid = 0;
        step();
        stop = 0;
        step();
        for (int c = 0; c < 100; c++) step();
        check("starve_10", {32'd0, starve_count}, 64'd10);
        check("starve_wr0", {32'd0, wr_count}, 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            stop       = ($urandom_range(63) == 0);
            pause      = ($urandom_range(15) == 0);
            if ($urandom_range(31) == 0) sel = ~sel;
            if ($urandom_range(49) == 0) div_freq = $urandom_range(5);
            fifo_full  = ($urandom_range(7) == 0);
            case ($urandom_range(3))
                0:       fifo_used = 12'($urandom_range(4095));
                1:       fifo_used = 12'($urandom_range(HI + 2, HI - 2));
                2:       fifo_used = 12'($urandom_range(LO + 2, LO - 2));
                default: fifo_used = 12'($urandom_range(LO - 1));
            endcase
            src0_valid = ($urandom_range(3) != 0);
            src1_valid = ($urandom_range(3) != 0);
            src0_data  = $urandom;
            src1_data  = $urandom;
            step();
        end

        // Async reset during an active write drops wrreq at once without a flush.
        stop = 0; pause = 0; sel = 0; fifo_full = 0; fifo_used = 0; src0_valid = 1;
        bound = 0;
        do begin
            step();
            bound++;
        end while (!fifo_wrreq && bound < 20);
        check("pre_rst_wrreq", {63'd0, fifo_wrreq}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_wrreq", {63'd0, fifo_wrreq}, 64'd0);
        check("async_flush", {63'd0, fifo_flush}, 64'd0);
        check("async_state", {62'd0, state_o}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_fifo_sched.md
# audio_fifo_sched

Write-side controller for the audio sample FIFO that feeds the audio codec path. Selects one of two sample requesters (software stream from the Nios PIO path, or the DDS/modulation tone path), paces the tone path with a programmable sample-rate divider, and throttles all writes with watermark hysteresis on the FIFO fill level. Honours pause and stop from the processor, flushes the FIFO on stop, and keeps write and starvation counters for software.

## Interface
- DATA_W, 32, sample word width
- USED_W, 12, width of FIFO fill-level input
- HI_WM, 3072, fill level at which writes stop; must be ≤ 2^USED_W − 4
- LO_WM, 1024, fill level at which writes resume; must be < HI_WM
- clk  in  1  system clock; all logic in this domain
- reset_n  in  1  reset, asynchronous, active-low
- src0_data / src0_valid / src0_ready  in/in/out  DATA_W/1/1  software stream, valid/ready; unpaced
- src1_data / src1_valid / src1_ready  in/in/out  DATA_W/1/1  tone stream, valid/ready; paced by divider
- sel  in  1  0 = src0, 1 = src1
- pause  in  1  level; hold writes while high
- stop  in  1  level; stop and flush while high
- div_freq  in  32  sample period minus one, in clk cycles
- fifo_full  in  1  FIFO full flag
- fifo_used  in  USED_W  FIFO fill level
- fifo_wrreq  out  1  FIFO write strobe, registered
- fifo_data  out  DATA_W  FIFO write data, registered
- fifo_flush  out  1  one-cycle FIFO clear pulse
- state_o  out  2  current state encoding
- wr_count  out  32  samples written since last stop
- starve_count  out  32  pace ticks with no valid src1 sample in FILL

## Operation
- States: STOPPED=0, FILL=1, THROTTLE=2, PAUSED=3. Reset enters STOPPED.
- STOPPED: no accepts. stop low → FILL next cycle; counters cleared on entry.
- FILL: accept from selected source when accept condition true; fifo_used ≥ HI_WM → THROTTLE.
- THROTTLE: no accepts; fifo_used ≤ LO_WM → FILL.
- PAUSED: no accepts, counters hold; pause low → FILL (watermark re-evaluated next cycle).
- Priority each cycle: stop > pause > watermark. stop high from any non-STOPPED state → STOPPED with fifo_flush pulsed exactly one cycle on entry.
- Accept (combinational): state==FILL & !fifo_full & selected valid & (sel==0 | tick). Selected ready = accept; unselected ready = 0.
- sel change: one-cycle gap — no accept in the cycle after sel toggles; divider restarts on toggle.
- Divider: counter loads div_freq, decrements per clk, tick on 0 then reloads; div_freq=0 → tick every cycle; div_freq change takes effect at next reload. Counter runs only in FILL/THROTTLE.
- Starvation: tick in FILL with sel==1, !src1_valid → starve_count+1. Counters saturate at 2^32−1.
- Tone path is real-time: no queueing of missed ticks.

## Timing
- Reset values: fifo_wrreq=0, fifo_data=0, fifo_flush=0, state_o=0, wr_count=0, starve_count=0, ready outputs 0.
- Accept in cycle N → fifo_wrreq=1 and fifo_data=sample in N+1; wr_count increments in N+1.
- Max one write per cycle; back-to-back src0 writes sustain 1/clk in FILL.
- Watermark compare uses registered state; up to 2 extra writes after fifo_used crosses HI_WM are allowed (hence HI_WM margin). fifo_full gates accept directly: fifo_wrreq never issued for a sample accepted while fifo_full high.
- stop asserted in cycle N: no accept in N; write from accept in N−1 still completes in N; fifo_flush high in N+1; counters zero in N+1.
- Async reset mid-write: wrreq drops immediately, no flush pulse.

## Test plan
- Reset then stop=0, sel=0, src0_valid=1 constant, fifo_used=0 → FILL in 1 cycle, fifo_wrreq high every cycle from cycle 2, wr_count increments by 1 per cycle.
- sel=1, div_freq=3, src1_valid=1 → exactly one wrreq every 4 cycles; src1_ready pulses 1 cycle per tick; src0_ready stays 0.
- Ramp fifo_used to 3072 → THROTTLE, no wrreq within 3 cycles; lower to 1025 → stays THROTTLE; 1024 → FILL, writes resume.
- sel=1, div_freq=9, src1_valid=0 for 100 cycles in FILL → starve_count=10, wr_count unchanged.
- pause=1 then stop=1 together during FILL → STOPPED (stop wins), one fifo_flush pulse, wr_count=0; stop=0 → FILL.
- fifo_full=1 with fifo_used below HI_WM → no ready, no wrreq; release → writes resume next cycle.
